// File: rtl/min_share_arb_pkg.sv
// Shared defaults and helpers for the min_share_arb slice: requester count,
// operand width, result-counter width and the id-width helper.
package min_share_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int CNT_W    = 16;

  // Number of bits needed to encode an index in 0..n-1 (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/min_share_arb_min2.sv
// Registered unsigned two-input minimum. The output register only loads when
// en is high, so the last result stays put while the consumer stalls.
module min2_reg
  import min_share_arb_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] d
);

  // Unsigned minimum; equal operands return that common value.
  function automatic logic [DW-1:0] umin(input logic [DW-1:0] x,
                                         input logic [DW-1:0] y);
    return (x <= y) ? x : y;
  endfunction

  // Result register: cleared by reset, loaded only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  d <= '0;
    else if (en) d <= umin(a, b);
  end

endmodule

// File: rtl/min_share_arb.sv
// Round-robin arbiter sharing one registered min unit among NREQ requesters.
// A grant is issued combinationally whenever the single result slot is free;
// the granted operands are captured on that edge and the result, tagged with
// the requester index, appears one cycle later and is held until accepted.
module min_share_arb
  import min_share_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int DW   = DW_DEF,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   a_i,
  input  logic [NREQ*DW-1:0]   b_i,
  output logic [NREQ-1:0]      gnt,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DW-1:0]        res_data,
  output logic [IDW-1:0]       res_id,
  output logic [CNT_W-1:0]     done_cnt
);

  logic [IDW-1:0]   ptr_p0;
  logic [IDW-1:0]   ptr_nxt;
  logic             slot_free;
  logic             gnt_any;
  logic [IDW-1:0]   gnt_idx;
  logic [DW-1:0]    a_sel;
  logic [DW-1:0]    b_sel;
  logic             vld_p1;
  logic [IDW-1:0]   res_id_p1;
  logic [CNT_W-1:0] done_cnt_p1;

  // (p + k) mod NREQ for k in 0..NREQ-1; handles non-power-of-two NREQ.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p,
                                              input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // The slot can take a new result if it is empty or being drained this cycle.
  assign slot_free = !res_valid || res_ready;

  // Round-robin search starting at ptr; gated off in reset and when the slot is busy.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    ptr_nxt = ptr_p0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req[wrap_idx(ptr_p0, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap_idx(ptr_p0, k);
      end
    end
    if (!(rst_n && slot_free)) begin
      gnt_any = 1'b0;
      gnt_idx = '0;
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
      ptr_nxt      = wrap_idx(gnt_idx, 1);
    end
  end

  // Operand mux selecting the granted requester's A/B pair.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        a_sel = a_i[i*DW +: DW];
        b_sel = b_i[i*DW +: DW];
      end
    end
  end

  // ---- stage p0 -> p1: operands captured into the min unit on a grant ----
  min2_reg #(
    .DW (DW)
  ) u_min2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (gnt_any),
    .a     (a_sel),
    .b     (b_sel),
    .d     (res_data)
  );

  // Priority pointer: moves past the winner, holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_p0 <= '0;
    else        ptr_p0 <= ptr_nxt;
  end

  // Result valid and owner id: loaded on grant, cleared on accept without a new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      res_id_p1 <= '0;
    end else if (gnt_any) begin
      vld_p1    <= 1'b1;
      res_id_p1 <= gnt_idx;
    end else if (res_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  // Accepted-result counter, free-running modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 done_cnt_p1 <= '0;
    else if (vld_p1 && res_ready) done_cnt_p1 <= done_cnt_p1 + CNT_W'(1);
  end

  assign res_valid = vld_p1;
  assign res_id    = res_id_p1;
  assign done_cnt  = done_cnt_p1;

endmodule

// File: tb/tb_min_share_arb.sv
module tb_min_share_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [3:0]  gnt;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
  logic [15:0] done_cnt;

  logic [7:0]  av [4];
  logic [7:0]  bv [4];

  int checks = 0;
  int errors = 0;

  assign a_i = {av[3], av[2], av[1], av[0]};
  assign b_i = {bv[3], bv[2], bv[1], bv[0]};

  min_share_arb #(.NREQ(4), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_i       (a_i),
    .b_i       (b_i),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b1111;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      av[i] = 8'h00;
      bv[i] = 8'h00;
    end

    // Reset state, gnt suppressed while in reset even with requests pending
    tick();
    settle();
    chk("rst_valid", res_valid, 0);
    chk("rst_data",  res_data, 0);
    chk("rst_id",    res_id, 0);
    chk("rst_cnt",   done_cnt, 0);
    chk("rst_gnt",   gnt, 0);
    tick();
    rst_n = 1'b1;
    req   = 4'b0000;
    tick();

    // Round-robin over all four requesters
    for (int i = 0; i < 4; i++) begin
      av[i] = 8'h10;
      bv[i] = 8'(i + 1);
    end
    req = 4'b1111;
    settle();
    chk("rr_gnt0", gnt, 4'b0001);
    tick();
    settle();
    chk("rr_gnt1", gnt, 4'b0010);
    chk("rr_id0", res_id, 0);
    chk("rr_data0", res_data, 8'h01);
    chk("rr_valid0", res_valid, 1);
    tick();
    settle();
    chk("rr_gnt2", gnt, 4'b0100);
    chk("rr_id1", res_id, 1);
    chk("rr_data1", res_data, 8'h02);
    tick();
    settle();
    chk("rr_gnt3", gnt, 4'b1000);
    chk("rr_id2", res_id, 2);
    chk("rr_data2", res_data, 8'h03);
    tick();
    req = 4'b0000;
    settle();
    chk("rr_gnt_none", gnt, 0);
    chk("rr_id3", res_id, 3);
    chk("rr_data3", res_data, 8'h04);
    chk("rr_cnt3", done_cnt, 3);
    tick();
    settle();
    chk("rr_drain_valid", res_valid, 0);
    chk("rr_cnt4", done_cnt, 4);

    // Backpressure: pending result held 3 cycles, req[2] waits, then no-gap handoff
    av[0] = 8'h20; bv[0] = 8'h30;
    req = 4'b0001;
    res_ready = 1'b0;
    settle();
    chk("bp_gnt0", gnt, 4'b0001);
    tick();
    av[2] = 8'h55; bv[2] = 8'h44;
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("bp_gnt_blocked", gnt, 0);
      chk("bp_valid_hold", res_valid, 1);
      chk("bp_data_hold", res_data, 8'h20);
      chk("bp_id_hold", res_id, 0);
      tick();
    end
    res_ready = 1'b1;
    settle();
    chk("bp_gnt2", gnt, 4'b0100);
    tick();
    req = 4'b0000;
    settle();
    chk("bp_valid_next", res_valid, 1);
    chk("bp_data_next", res_data, 8'h44);
    chk("bp_id_next", res_id, 2);
    chk("bp_cnt", done_cnt, 5);
    tick();
    settle();
    chk("bp_drain", res_valid, 0);

    // Pointer wrap: grant to 1 (ptr 3 -> 2), then req 0011 wraps to 0, then 1
    av[1] = 8'h07; bv[1] = 8'h09;
    av[0] = 8'h11; bv[0] = 8'h12;
    req = 4'b0010;
    settle();
    chk("wr_gnt1", gnt, 4'b0010);
    tick();
    req = 4'b0011;
    settle();
    chk("wr_gnt0", gnt, 4'b0001);
    chk("wr_data1", res_data, 8'h07);
    chk("wr_id1", res_id, 1);
    tick();
    settle();
    chk("wr_gnt1b", gnt, 4'b0010);
    chk("wr_data0", res_data, 8'h11);
    chk("wr_id0", res_id, 0);
    tick();
    req = 4'b0000;
    settle();
    chk("wr_data1b", res_data, 8'h07);
    chk("wr_id1b", res_id, 1);
    tick();

    // Boundary operands and unsigned compare (ptr is 2 here)
    av[3] = 8'hFF; bv[3] = 8'hFF;
    req = 4'b1000;
    settle();
    chk("bd_gnt3", gnt, 4'b1000);
    tick();
    av[3] = 8'h00; bv[3] = 8'h80;
    settle();
    chk("bd_data_ff", res_data, 8'hFF);
    chk("bd_id_ff", res_id, 3);
    chk("bd_gnt3b", gnt, 4'b1000);
    tick();
    av[0] = 8'h80; bv[0] = 8'h7F;
    req = 4'b0001;
    settle();
    chk("bd_data_00", res_data, 8'h00);
    chk("bd_id_00", res_id, 3);
    tick();
    req = 4'b0000;
    settle();
    chk("bd_data_7f", res_data, 8'h7F);
    chk("bd_id_7f", res_id, 0);
    tick();

    // Async reset mid-stream with a stalled result (ptr is 1 here)
    av[2] = 8'h33; bv[2] = 8'h66;
    req = 4'b0100;
    settle();
    chk("ar_gnt2", gnt, 4'b0100);
    tick();
    req = 4'b0010;
    res_ready = 1'b0;
    settle();
    chk("ar_pending", res_valid, 1);
    chk("ar_pending_data", res_data, 8'h33);
    rst_n = 1'b0;
    settle();
    chk("ar_valid", res_valid, 0);
    chk("ar_data", res_data, 0);
    chk("ar_id", res_id, 0);
    chk("ar_cnt", done_cnt, 0);
    chk("ar_gnt", gnt, 0);
    tick();
    tick();
    settle();
    chk("ar_valid_hold", res_valid, 0);
    rst_n = 1'b1;
    req = 4'b0000;
    res_ready = 1'b1;
    tick();
    settle();
    chk("ar_discarded", res_valid, 0);
    req = 4'b1111;
    settle();
    chk("ar_first_gnt", gnt, 4'b0001);
    tick();
    req = 4'b0000;
    settle();
    chk("ar_first_id", res_id, 0);
    chk("ar_first_data", res_data, 8'h7F);
    tick();
    settle();
    chk("ar_cnt1", done_cnt, 1);

    // Counter wrap with a single requester granted every cycle
    req = 4'b0001;
    for (int k = 0; k < 65535; k++) begin
      if ((k % 4096) == 0) begin
        settle();
        chk("wp_single_gnt", gnt, 4'b0001);
      end
      tick();
    end
    settle();
    chk("wp_cnt_ffff", done_cnt, 16'hFFFF);
    chk("wp_valid", res_valid, 1);
    tick();
    settle();
    chk("wp_cnt_wrap", done_cnt, 16'h0000);
    req = 4'b0000;
    tick();
    settle();
    chk("wp_cnt_after", done_cnt, 16'h0001);
    chk("wp_drain", res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
